stream_accumulator: RTL and testbench

- Downstream consumer of the adder's sum channel S.
- Accepts COUNT consecutive S tokens, sums them, and emits one total token on channel T per group.
- Dataflow equivalent: while { acc = 0; repeat COUNT { acc += S.recv() }; T.send(acc) }.
- Uses the same valid/ready channel convention as the rest of the pipeline. The output is registered; a new group may accumulate while the previous total waits on T.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/chan_out_reg.sv | 37 +++
 rtl/stream_accumulator.sv | 67 ++++++
 tb/tb_stream_accumulator.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants and width helpers for the adder / accumulator pipeline.
package pipeline_pkg;

  // Default sum width (adder WIDTH+1 with adder WIDTH=8) and group size.
  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_COUNT = 4;

  // Bits needed to index n items; never less than 1 so counters stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chan_out_reg.sv
// One-deep registered valid/data output stage for a valid/ready channel.
// A load always wins over a drain so back-to-back tokens leave no bubble.
module chan_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // Room for a new token when empty or when the current one leaves this cycle.
  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // Output register: load replaces the token, drain clears valid but keeps data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_accumulator.sv
// Sums each group of COUNT input tokens from channel S and emits the total on T.
// A new group keeps accumulating while the previous total waits downstream;
// only the final token of a group has to wait for the output register.
module stream_accumulator
  import pipeline_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  COUNT = DEFAULT_COUNT,
  localparam int CW    = clog2_min1(COUNT),
  localparam int TW    = WIDTH + $clog2(COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          S_valid,
  output logic          S_ready,
  input  logic [WIDTH-1:0] S_data,
  output logic          T_valid,
  input  logic          T_ready,
  output logic [TW-1:0] T_data,
  output logic [CW-1:0] group_idx
);

  logic [TW-1:0] acc_reg;
  logic [CW-1:0] cnt_reg;
  logic          last;
  logic          s_fire;
  logic          t_load_ready;
  logic [TW-1:0] total_next;

  assign last       = (cnt_reg == CW'(COUNT - 1));
  // Only the closing token needs space in the output register.
  assign S_ready    = !last || t_load_ready;
  assign s_fire     = S_valid && S_ready;
  // TW is wide enough for COUNT maximal tokens, so this never wraps.
  assign total_next = acc_reg + TW'(S_data);
  assign group_idx  = cnt_reg;

  // Group accumulator and position counter; both restart after the closing token.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (s_fire) begin
      if (last) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else begin
        acc_reg <= total_next;
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  chan_out_reg #(
    .W (TW)
  ) u_t_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (s_fire && last),
    .load_data (total_next),
    .in_ready  (t_load_ready),
    .out_valid (T_valid),
    .out_ready (T_ready),
    .out_data  (T_data)
  );

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator: a COUNT=4 instance and a COUNT=1
// instance share the S stimulus; a negedge monitor checks both against a
// group-sum reference model with a one-entry output queue.
module tb_stream_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        S_valid;
  logic [8:0]  S_data;
  logic        S_ready0, S_ready1;
  logic        T_valid0, T_valid1;
  logic        T_ready0, T_ready1;
  logic [10:0] T_data0;
  logic [8:0]  T_data1;
  logic [1:0]  group_idx0;
  logic        group_idx1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state per instance: partial group and pending totals.
  int unsigned q0[$];
  int unsigned q1[$];
  int          part_sum[2];
  int          part_n[2];
  int          count_of[2];

  always #5 clk = ~clk;

  stream_accumulator #(.WIDTH(9), .COUNT(4)) dut4 (
    .clk(clk), .reset(reset),
    .S_valid(S_valid), .S_ready(S_ready0), .S_data(S_data),
    .T_valid(T_valid0), .T_ready(T_ready0), .T_data(T_data0),
    .group_idx(group_idx0)
  );

  stream_accumulator #(.WIDTH(9), .COUNT(1)) dut1 (
    .clk(clk), .reset(reset),
    .S_valid(S_valid), .S_ready(S_ready1), .S_data(S_data),
    .T_valid(T_valid1), .T_ready(T_ready1), .T_data(T_data1),
    .group_idx(group_idx1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int unsigned qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endfunction

  function automatic void qpush(input int k, input int unsigned v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  // Monitor: compare DUT outputs with the model, then advance the model by
  // the handshakes that will occur on the coming posedge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic tv, tr, sr, exp_ready;
      int unsigned td;
      int gi;
      tv = (k == 0) ? T_valid0 : T_valid1;
      tr = (k == 0) ? T_ready0 : T_ready1;
      sr = (k == 0) ? S_ready0 : S_ready1;
      td = (k == 0) ? int'(T_data0) : int'(T_data1);
      gi = (k == 0) ? int'(group_idx0) : int'(group_idx1);
      if (reset) begin
        if (k == 0) q0.delete(); else q1.delete();
        part_sum[k] = 0;
        part_n[k]   = 0;
      end else begin
        exp_ready = (part_n[k] != count_of[k] - 1) || (qsize(k) == 0) || tr;
        check($sformatf("t_valid%0d", k), tv, qsize(k) != 0);
        if (qsize(k) != 0) check($sformatf("t_data%0d", k), td, qfront(k));
        check($sformatf("group_idx%0d", k), gi, part_n[k]);
        check($sformatf("s_ready%0d", k), sr, exp_ready);
        if (qsize(k) != 0 && tr) qpop(k);
        if (S_valid && exp_ready) begin
          part_sum[k] += int'(S_data);
          part_n[k]++;
          if (part_n[k] == count_of[k]) begin
            qpush(k, part_sum[k]);
            part_sum[k] = 0;
            part_n[k]   = 0;
          end
        end
      end
    end
  end

  // Offer one token and hold it until the COUNT=4 instance accepts it.
  task automatic send0(input int v);
    logic rdy;
    int   waited;
    waited  = 0;
    S_valid = 1'b1;
    S_data  = 9'(v);
    forever begin
      @(negedge clk);
      rdy = S_ready0;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 100) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout @%0t: token %0d not accepted within 100 cycles", $time, v);
        break;
      end
    end
    S_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    count_of[0] = 4;
    count_of[1] = 1;
    part_sum[0] = 0; part_sum[1] = 0;
    part_n[0]   = 0; part_n[1]   = 0;
    reset    = 1'b1;
    S_valid  = 1'b0;
    S_data   = '0;
    T_ready0 = 1'b1;
    T_ready1 = 1'b1;
    idle(3);
    reset = 1'b0;
    check("reset_t_valid0", T_valid0, 0);
    check("reset_t_data0", T_data0, 0);
    check("reset_group_idx0", group_idx0, 0);
    check("reset_t_valid1", T_valid1, 0);
    check("reset_t_data1", T_data1, 0);

    // Basic group.
    send0(3); send0(5); send0(7); send0(9);
    check("basic_total_valid", T_valid0, 1);
    check("basic_total", T_data0, 24);
    idle(1);

    // Maximum values.
    repeat (4) send0(511);
    check("max_total", T_data0, 2044);
    idle(1);

    // Output backpressure across two groups.
    T_ready0 = 1'b0;
    repeat (4) send0(1);
    repeat (3) send0(2);
    check("stall_total_held", T_data0, 4);
    S_valid = 1'b1;
    S_data  = 9'd2;
    repeat (2) begin
      @(negedge clk);
      check("stall_s_ready_low", S_ready0, 0);
      check("stall_idx", group_idx0, 3);
      @(posedge clk);
      #1;
    end
    T_ready0 = 1'b1;
    send0(2);
    check("stall_release_total", T_data0, 8);
    check("stall_release_valid", T_valid0, 1);
    idle(1);

    // Idle cycles between tokens.
    send0(10); idle(1); send0(20); idle(1); send0(30); idle(1); send0(40);
    check("bubble_total", T_data0, 100);
    idle(1);

    // Reset in the middle of a group discards the partial sum.
    send0(6); send0(6);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midreset_t_valid", T_valid0, 0);
    check("midreset_idx", group_idx0, 0);
    send0(1); send0(2); send0(3); send0(4);
    check("midreset_next_total", T_data0, 10);
    idle(1);

    // Pass-through behaviour of the COUNT=1 instance.
    send0(7);
    check("count1_first", T_data1, 7);
    check("count1_s_ready", S_ready1, 1);
    send0(8);
    check("count1_second", T_data1, 8);
    check("count1_valid", T_valid1, 1);

    // Randomized traffic with random backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      S_valid  = ($urandom % 4) != 0;
      S_data   = (($urandom % 5) == 0) ? 9'd511 : 9'($urandom_range(0, 511));
      T_ready0 = ($urandom % 3) != 0;
      T_ready1 = ($urandom % 4) != 0;
      reset    = ($urandom % 400) == 0;
      @(posedge clk);
      #1;
    end

    // Drain.
    reset    = 1'b0;
    S_valid  = 1'b0;
    T_ready0 = 1'b1;
    T_ready1 = 1'b1;
    idle(4);
    check("drain_t_valid0", T_valid0, 0);
    check("drain_t_valid1", T_valid1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
